lsu_itf_arbiter: RTL

//  2:1 arbiter/mux for the LSU request/ack interface (SOPHON_PKG::lsu_req_t/lsu_ack_t).
//  - Merges two LSU initiators (m0: core LSU, m1: debug/DMA) onto one LSU target port,
//    i.e. the converging counterpart of the LSU address demux.
//  - Round-robin or fixed-priority grant, grant lock until ack, per-request timeout

---
 rtl/lsu_itf_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/lsu_itf_arbiter.sv
// 2:1 arbiter for the LSU request/ack interface: merges core LSU (m0) and debug/DMA (m1)
// onto one target port with round-robin or fixed priority, grant lock and ack timeout.

package sophon_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  amo;
      logic [3:0]  strb;
      logic [1:0]  size;
   } lsu_req_t;

   typedef struct packed {
      logic        ack;
      logic        error;
      logic [31:0] rdata;
   } lsu_ack_t;

endpackage

module lsu_itf_arbiter
   import sophon_pkg::*;
#(
   parameter bit          RR_EN       = 1'b1,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  lsu_req_t lsu_req_m0_i,
   output lsu_ack_t lsu_ack_m0_o,
   input  lsu_req_t lsu_req_m1_i,
   output lsu_ack_t lsu_ack_m1_o,
   output lsu_req_t lsu_req_o,
   input  lsu_ack_t lsu_ack_i,
   output logic     timeout_o
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   localparam lsu_req_t         IdleReq = '{size: 2'b01, default: '0};
   localparam logic [CNT_W-1:0] TmoVal  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CntMax  = '1;

   state_e           state_q, state_d;
   logic             prio_q, prio_d;
   logic             owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic     sel;
   logic     fwd;
   logic     ack_hit;
   logic     tmo_hit;
   lsu_req_t sel_req;
   lsu_ack_t tmo_ack;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   // Selection: in IDLE the grant is decided combinationally; in BUSY it is locked to owner.
   always_comb begin
      sel = 1'b0;
      fwd = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (lsu_req_m0_i.req && lsu_req_m1_i.req) begin
               sel = RR_EN ? prio_q : 1'b0;
            end else begin
               sel = lsu_req_m1_i.req;
            end
            fwd = lsu_req_m0_i.req | lsu_req_m1_i.req;
         end
         StBusy: begin
            sel = owner_q;
            fwd = owner_q ? lsu_req_m1_i.req : lsu_req_m0_i.req;
         end
         default: ;
      endcase
   end

   assign sel_req = sel ? lsu_req_m1_i : lsu_req_m0_i;
   // A target ack with nothing forwarded is a late ack after an abort and is dropped.
   assign ack_hit = fwd & lsu_ack_i.ack;
   assign tmo_hit = (TIMEOUT_CYC != 0) && (state_q == StBusy) && fwd && !lsu_ack_i.ack &&
                    (cnt_q == TmoVal);
   assign tmo_ack = '{ack: 1'b1, error: 1'b1, rdata: 32'h0};

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (fwd) begin
               if (ack_hit) begin
                  prio_d = ~sel;
               end else begin
                  owner_d = sel;
                  cnt_d   = CNT_W'(1);
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (!fwd) begin
               // Owner withdrew without an ack: release silently.
               state_d = StIdle;
               cnt_d   = '0;
            end else if (ack_hit || tmo_hit) begin
               state_d = StIdle;
               prio_d  = ~owner_q;
               cnt_d   = '0;
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      lsu_req_o    = fwd ? sel_req : IdleReq;
      lsu_ack_m0_o = '0;
      lsu_ack_m1_o = '0;
      timeout_o    = tmo_hit;
      if (ack_hit) begin
         if (sel) lsu_ack_m1_o = lsu_ack_i;
         else     lsu_ack_m0_o = lsu_ack_i;
      end else if (tmo_hit) begin
         if (sel) lsu_ack_m1_o = tmo_ack;
         else     lsu_ack_m0_o = tmo_ack;
      end
   end

endmodule
